// File: rtl/alu_addsub_flags_pkg.sv
// Shared ALU definitions: function-code layout and the flag bundle seen by the comparator.
package alu_addsub_flags_pkg;

    localparam int unsigned FUN_W   = 6;
    localparam int unsigned SUB_BIT = 0;

    typedef logic [FUN_W-1:0] alufun_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    function automatic logic is_sub(input alufun_t fun);
        return fun[SUB_BIT];
    endfunction

endpackage

// File: rtl/alu_addsub_flags_if.sv
// Valid/ready operation bus between the issuing stage, the add/sub pipe and the comparator.
interface alu_addsub_flags_if #(
    parameter int unsigned WIDTH = 32
) ();
    import alu_addsub_flags_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    alufun_t          ALUFun_in;
    logic             Sign;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Z;
    logic             V;
    logic             N;
    alufun_t          ALUFun_out;

    modport master (
        output in_valid, A, B, ALUFun_in, Sign, out_ready,
        input  in_ready, out_valid, S, Z, V, N, ALUFun_out
    );

    modport slave (
        input  in_valid, A, B, ALUFun_in, Sign, out_ready,
        output in_ready, out_valid, S, Z, V, N, ALUFun_out
    );

endinterface

// File: rtl/alu_addsub_flags_addsub_half.sv
// Half-width ripple adder with carry in/out; one instance per pipeline stage.
module addsub_half #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

endmodule

// File: rtl/alu_addsub_flags.sv
// Two-stage add/sub pipe producing S and {Z,V,N}; the carry chain is split at WIDTH/2.
module alu_addsub_flags
    import alu_addsub_flags_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    alu_addsub_flags_if.slave   bus
);

    localparam int unsigned HALF = WIDTH / 2;

    // Pipeline control: the {v1, v2} pair is the whole state machine.
    logic r_v1;
    logic r_v2;
    logic w_adv2;
    logic w_in_ready;
    logic w_accept;

    assign w_adv2     = r_v1 && (!r_v2 || bus.out_ready);
    assign w_in_ready = !r_v1 || w_adv2;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Stage 1: low half plus operand capture for the high half.
    logic             w_sub_in;
    logic [WIDTH-1:0] w_b_eff;
    logic [HALF-1:0]  w_lo_sum;
    logic             w_lo_cout;

    assign w_sub_in = is_sub(bus.ALUFun_in);
    assign w_b_eff  = w_sub_in ? ~bus.B : bus.B;

    addsub_half #(.W(HALF)) u_lo (
        .i_a    (bus.A[HALF-1:0]),
        .i_b    (w_b_eff[HALF-1:0]),
        .i_cin  (w_sub_in),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    logic [HALF-1:0] r_lo_sum;
    logic            r_lo_cout;
    logic [HALF-1:0] r_a_hi;
    logic [HALF-1:0] r_b_hi;
    logic            r_lo_zero;
    logic            r_sign;
    alufun_t         r_fun1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_lo_sum  <= '0;
            r_lo_cout <= 1'b0;
            r_a_hi    <= '0;
            r_b_hi    <= '0;
            r_lo_zero <= 1'b0;
            r_sign    <= 1'b0;
            r_fun1    <= '0;
        end else begin
            if (w_accept) begin
                r_v1      <= 1'b1;
                r_lo_sum  <= w_lo_sum;
                r_lo_cout <= w_lo_cout;
                r_a_hi    <= bus.A[WIDTH-1:HALF];
                r_b_hi    <= w_b_eff[WIDTH-1:HALF];
                r_lo_zero <= (w_lo_sum == '0);
                r_sign    <= bus.Sign;
                r_fun1    <= bus.ALUFun_in;
            end else if (w_adv2) begin
                r_v1 <= 1'b0;
            end
        end
    end

    // Stage 2: high half and flag generation.
    logic [HALF-1:0] w_hi_sum;
    logic            w_hi_cout;
    flags_t          w_flags;

    addsub_half #(.W(HALF)) u_hi (
        .i_a    (r_a_hi),
        .i_b    (r_b_hi),
        .i_cin  (r_lo_cout),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    always_comb begin
        w_flags   = '0;
        w_flags.z = r_lo_zero && (w_hi_sum == '0);
        if (r_sign) begin
            w_flags.n = w_hi_sum[HALF-1];
            w_flags.v = (r_a_hi[HALF-1] == r_b_hi[HALF-1]) &&
                        (w_hi_sum[HALF-1] != r_a_hi[HALF-1]);
        end else begin
            // Unsigned: carry on add, borrow (inverted carry) on subtract.
            w_flags.n = 1'b0;
            w_flags.v = w_hi_cout ^ is_sub(r_fun1);
        end
    end

    logic [WIDTH-1:0] r_s;
    flags_t           r_flags;
    alufun_t          r_fun2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2    <= 1'b0;
            r_s     <= '0;
            r_flags <= '0;
            r_fun2  <= '0;
        end else begin
            if (w_adv2) begin
                r_v2    <= 1'b1;
                r_s     <= {w_hi_sum, r_lo_sum};
                r_flags <= w_flags;
                r_fun2  <= r_fun1;
            end else if (bus.out_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_v2;
    assign bus.S          = r_s;
    assign bus.Z          = r_flags.z;
    assign bus.V          = r_flags.v;
    assign bus.N          = r_flags.n;
    assign bus.ALUFun_out = r_fun2;

endmodule

// File: tb/tb_alu_addsub_flags.sv
// Directed and randomized checks of the two-stage add/sub pipe with flag generation.
module tb_alu_addsub_flags;
    import alu_addsub_flags_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_addsub_flags_if #(.WIDTH(W)) bus ();

    alu_addsub_flags #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         z;
        logic         v;
        logic         n;
        alufun_t      fun;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur_exp;
    int           n_cmp = 0;
    int           n_mis = 0;
    int           emit_cnt;
    int           cyc;
    int           first_emit;
    int           last_emit;
    logic         accepted;
    logic         hold_prev;
    logic [W-1:0] prev_s;
    alufun_t      prev_fun;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, req);
        end
    endtask

    // Reference: 33-bit add/subtract; bit 32 is carry on add and borrow on subtract.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input alufun_t fun, input logic sign);
        exp_t        e;
        logic [W:0]  r;
        if (fun[0]) r = {1'b0, a} - {1'b0, b};
        else        r = {1'b0, a} + {1'b0, b};
        e.s   = r[W-1:0];
        e.z   = (r[W-1:0] == '0);
        e.fun = fun;
        if (sign) begin
            e.n = r[W-1];
            if (fun[0]) e.v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            else        e.v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            e.n = 1'b0;
            e.v = r[W];
        end
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input alufun_t fun, input logic sign);
        bus.A         = a;
        bus.B         = b;
        bus.ALUFun_in = fun;
        bus.Sign      = sign;
        cur_exp       = model(a, b, fun, sign);
    endtask

    // One clock: observe both handshakes at the negedge, then advance to posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (hold_prev) begin
            check("hold_s", bus.S, prev_s);
            check("hold_fun", 32'(bus.ALUFun_out), 32'(prev_fun));
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_s    = bus.S;
        prev_fun  = bus.ALUFun_out;
        accepted  = bus.in_valid && bus.in_ready;
        if (accepted) exp_q.push_back(cur_exp);
        if (bus.out_valid && bus.out_ready) begin
            if (emit_cnt == 0) first_emit = cyc;
            last_emit = cyc;
            emit_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(bus.out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_s", bus.S, e.s);
                check("sb_z", 32'(bus.Z), 32'(e.z));
                check("sb_v", 32'(bus.V), 32'(e.v));
                check("sb_n", 32'(bus.N), 32'(e.n));
                check("sb_fun", 32'(bus.ALUFun_out), 32'(e.fun));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty pipe with hand-computed results and latency checks.
    task automatic run_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input alufun_t fun, input logic sign, input logic [W-1:0] es,
                           input logic ez, input logic ev, input logic en);
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'(1));
        bus.A = a; bus.B = b; bus.ALUFun_in = fun; bus.Sign = sign;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'(0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
        check({tag, "_s"}, bus.S, es);
        check({tag, "_z"}, 32'(bus.Z), 32'(ez));
        check({tag, "_v"}, 32'(bus.V), 32'(ev));
        check({tag, "_n"}, 32'(bus.N), 32'(en));
        check({tag, "_fun"}, 32'(bus.ALUFun_out), 32'(fun));
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(bus.out_valid), 32'(0));
    endtask

    // Eight ops back-to-back; optional 3-cycle out_ready drop mid-stream.
    task automatic run_stream(input string tag, input logic stall);
        int idx;
        idx = 0; emit_cnt = 0; hold_prev = 1'b0;
        for (int c = 0; c < 60 && (idx < 8 || exp_q.size() != 0); c++) begin
            if (idx < 8) begin
                drive(W'(idx) * 32'h0101_0101, W'(idx + 1), alufun_t'(idx + 8), 1'(idx % 2));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = !(stall && c >= 4 && c < 7);
            #1;
            if (!bus.out_ready) check({tag, "_backpressure"}, 32'(bus.in_ready), 32'(0));
            step();
            if (accepted) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_ops"}, 32'(idx), 32'(8));
        check({tag, "_emits"}, 32'(emit_cnt), 32'(8));
        check({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
        if (!stall) check({tag, "_consecutive"}, 32'(last_emit - first_emit), 32'(7));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ov"}, 32'(bus.out_valid), 32'(0));
        check({tag, "_s"}, bus.S, 32'(0));
        check({tag, "_zvn"}, {29'(0), bus.Z, bus.V, bus.N}, 32'(0));
        check({tag, "_fun"}, 32'(bus.ALUFun_out), 32'(0));
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] specials [7];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           idx;
        logic         have;

        specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                     32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0000};
        cyc = 0; emit_cnt = 0; first_emit = 0; last_emit = 0; hold_prev = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.ALUFun_in = '0; bus.Sign = 1'b0;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero_outputs("reset_state");

        run_dir("add_sovf",    32'h7FFF_FFFF, 32'h0000_0001, 6'h20, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        run_dir("sub_borrow",  32'h0000_0003, 32'h0000_0005, 6'h01, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        run_dir("sub_eq_cry",  32'h0001_FFFF, 32'h0001_FFFF, 6'h01, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_dir("sub_sovf",    32'h8000_0000, 32'h0000_0001, 6'h33, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_dir("add_ucarry",  32'hFFFF_FFFF, 32'h0000_0001, 6'h02, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_dir("add_sneg",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h3E, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        run_dir("add_lozero",  32'h0001_0000, 32'h0000_0000, 6'h04, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_dir("sub_sposit",  32'h0000_0005, 32'h0000_0003, 6'h11, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        run_stream("stream", 1'b0);
        run_stream("stall", 1'b1);

        // Fill both stages, then reset with an op still offered.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h1234_0000 + W'(i), 32'h0000_1111, 6'h00, 1'b0);
            bus.in_valid = 1'b1;
            step();
        end
        check("full_in_ready", 32'(bus.in_ready), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero_outputs("reset_mid");
        // Reset must win over an accept on an empty pipe.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_vs_accept", 32'(bus.out_valid), 32'(0));
        exp_q.delete();
        hold_prev = 1'b0;

        idx = 0; have = 1'b0;
        for (int c = 0; c < 40000 && (idx < 10000 || exp_q.size() != 0); c++) begin
            if (idx < 10000) begin
                if (!have) begin
                    case ($urandom_range(0, 3))
                        0: begin ra = specials[$urandom_range(0, 6)]; rb = specials[$urandom_range(0, 6)]; end
                        1: begin ra = $urandom; rb = ra; end
                        default: begin ra = $urandom; rb = $urandom; end
                    endcase
                    drive(ra, rb, alufun_t'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
                    have = 1'b1;
                end
                bus.in_valid = ($urandom_range(0, 4) != 0);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (accepted) begin
                idx++;
                have = 1'b0;
            end
        end
        check("rand_ops", 32'(idx), 32'(10000));
        check("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
